ysyx_22050039_ifu: RTL and testbench

Instruction fetch unit. It is the producer side of the `inst` interface consumed by the decode stage.
- Owns the PC.
- Issues word fetches to instruction memory over a valid/ready request channel and a valid response channel.
- Selects the 32-bit instruction from the 64-bit response beat and holds it to decode with a valid/ready handshake.
- Takes the next PC from the retire handshake: sequential `pc+4`, or the redirect `dnpc` when `pc_wen` is asserted.

---
 rtl/ysyx_22050039_ifu.sv | 120 ++++++++++++
 tb/tb_ysyx_22050039_ifu.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: owns the PC and fetches one instruction word at a time
// from instruction memory. It holds each instruction to decode until the
// instruction retires, then takes the next PC from the retire handshake.
module ysyx_22050039_ifu #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     INST_LEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned     TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_resp_valid,
   input  logic [63:0]         imem_resp_data,
   input  logic                imem_resp_err,
   output logic [INST_LEN-1:0] inst,
   output logic [XLEN-1:0]     pc,
   output logic                inst_valid,
   input  logic                inst_ready,
   input  logic                pc_wen,
   input  logic [XLEN-1:0]     dnpc,
   output logic                fetch_fault,
   output logic [XLEN-1:0]     fault_pc
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic [XLEN-1:0]     fault_pc_q, fault_pc_d;
   logic [INST_LEN-1:0] inst_q, inst_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [XLEN-1:0]     next_pc;

   // Sequential PC or redirect target; only consumed on the retire cycle.
   assign next_pc = pc_wen ? dnpc : (pc_q + {{(XLEN-3){1'b0}}, 3'd4});

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         fault_pc_q <= '0;
         inst_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_pc_q <= fault_pc_d;
         inst_q     <= inst_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state logic: request, wait for the beat, hold for decode, or fault.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_pc_d = fault_pc_q;
      inst_d     = inst_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         S_REQ: begin
            if (imem_req_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // A response arriving in the timeout cycle takes priority.
            if (imem_resp_valid) begin
               if (imem_resp_err) begin
                  state_d    = S_FAULT;
                  fault_pc_d = pc_q;
               end else begin
                  state_d = S_HOLD;
                  inst_d  = pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
               end
            end else if (cnt_d == 8'(TIMEOUT)) begin
               state_d    = S_FAULT;
               fault_pc_d = pc_q;
            end
         end
         S_HOLD: begin
            if (inst_ready) begin
               if (next_pc[1:0] != 2'b00) begin
                  state_d    = S_FAULT;
                  fault_pc_d = next_pc;
               end else begin
                  state_d = S_REQ;
                  pc_d    = next_pc;
               end
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (state_q == S_HOLD);
   assign fetch_fault    = (state_q == S_FAULT);
   assign inst           = inst_q;
   assign pc             = pc_q;
   assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Testbench for ysyx_22050039_ifu: a memory responder process, a decode-side
// stimulus process with a PC-level reference model, and a monitor that pops
// expected instructions from a scoreboard whenever a new instruction appears.
module tb_ysyx_22050039_ifu;

   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam logic [31:0] K0     = 32'h0F0F_0000;
   localparam logic [31:0] K1     = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [63:0] imem_resp_data;
   logic        imem_resp_err;
   logic [31:0] inst;
   logic [63:0] pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        pc_wen;
   logic [63:0] dnpc;
   logic        fetch_fault;
   logic [63:0] fault_pc;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   // Memory behaviour knobs, changed by the stimulus process.
   int unsigned ready_pct = 100;
   int unsigned max_lat   = 0;
   bit          mem_en    = 1'b1;
   bit          mem_drop  = 1'b0;
   logic [63:0] err_addr  = '1;

   logic [63:0] model_pc;

   ysyx_22050039_ifu #(
      .XLEN     (64),
      .INST_LEN (32),
      .RESET_PC (64'h8000_0000),
      .TIMEOUT  (255)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .inst            (inst),
      .pc              (pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .pc_wen          (pc_wen),
      .dnpc            (dnpc),
      .fetch_fault     (fetch_fault),
      .fault_pc        (fault_pc)
   );

   always #5 clk = ~clk;

   // Word-addressed view of instruction memory.
   function automatic logic [31:0] exp_inst(input logic [63:0] a);
      if (a[63:3] == RST_PC[63:3]) return a[2] ? 32'h0010_0093 : 32'h0000_0013;
      return a[31:0] ^ (a[2] ? K1 : K0);
   endfunction

   // Doubleword view returned by the memory: two words packed little-endian.
   function automatic logic [63:0] mem_dw(input logic [63:0] a);
      logic [63:0] base;
      base = {a[63:3], 3'b000};
      return {exp_inst(base + 64'd4), exp_inst(base)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input logic [63:0] p);
      exp_t e;
      e.pc   = p;
      e.inst = exp_inst(p);
      if (p != err_addr) sb.push_back(e);
   endfunction

   task automatic do_reset();
      rst        = 1'b1;
      inst_ready = 1'b0;
      tick();
      tick();
      sb.delete();
      rst      = 1'b0;
      model_pc = RST_PC;
      push(RST_PC);
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!inst_valid && n < budget) begin
         tick();
         n++;
      end
      if (!inst_valid) begin
         checks++;
         errors++;
         $display("FAIL wait_inst_valid: got no inst_valid within %0d cycles expected inst_valid", budget);
      end
   endtask

   task automatic wait_fault(input int budget);
      int n;
      n = 0;
      while (!fetch_fault && n < budget) begin
         tick();
         n++;
      end
      chk("fault_raised", 64'(fetch_fault), 64'd1);
   endtask

   // Retire the held instruction and advance the reference PC.
   task automatic retire(input bit wen, input logic [63:0] tgt);
      logic [63:0] nxt;
      inst_ready = 1'b1;
      pc_wen     = wen;
      dnpc       = tgt;
      tick();
      inst_ready = 1'b0;
      pc_wen     = 1'($urandom);
      dnpc       = {$urandom, $urandom};
      nxt = wen ? tgt : model_pc + 64'd4;
      if (nxt[1:0] == 2'b00) begin
         model_pc = nxt;
         push(nxt);
      end
   endtask

   // Memory responder: accepts a request, answers after a random latency.
   initial begin : mem
      logic        acc;
      logic        pend;
      logic [63:0] a;
      logic [63:0] paddr;
      int unsigned lat;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      imem_resp_err   = 1'b0;
      pend  = 1'b0;
      paddr = '0;
      lat   = 0;
      forever begin
         @(negedge clk);
         acc = imem_req_valid && imem_req_ready && !rst;
         a   = imem_req_addr;
         if (rst) pend = 1'b0;
         @(posedge clk);
         #1;
         if (mem_en) begin
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            if (acc && !mem_drop) begin
               pend  = 1'b1;
               paddr = a;
               lat   = $urandom_range(0, max_lat);
            end
            if (pend) begin
               if (lat == 0) begin
                  imem_resp_valid = 1'b1;
                  imem_resp_data  = mem_dw(paddr);
                  imem_resp_err   = (paddr == err_addr);
                  pend = 1'b0;
               end else begin
                  lat--;
               end
            end
            imem_req_ready = ($urandom_range(0, 99) < ready_pct);
         end
      end
   end

   // Monitor: each newly presented instruction is compared with the scoreboard;
   // a stalled instruction must stay put and no request may be in flight.
   initial begin : mon
      logic        pv;
      logic        pr;
      logic [63:0] ppc;
      logic [31:0] pinst;
      exp_t        e;
      pv = 1'b0;
      pr = 1'b0;
      ppc = '0;
      pinst = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0;
         end else begin
            if (inst_valid && !pv) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_inst: got pc %h inst %h expected no instruction", pc, inst);
               end else begin
                  e = sb.pop_front();
                  chk("sb_pc", pc, e.pc);
                  chk("sb_inst", 64'(inst), 64'(e.inst));
               end
            end else if (inst_valid && pv && !pr) begin
               chk("hold_pc", pc, ppc);
               chk("hold_inst", 64'(inst), 64'(pinst));
            end
            if (inst_valid) chk("no_req_in_hold", 64'(imem_req_valid), 64'd0);
            pv    = inst_valid;
            pr    = inst_ready;
            ppc   = pc;
            pinst = inst;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int          n;
      bit          wen;
      logic [63:0] tgt;
      rst        = 1'b1;
      inst_ready = 1'b0;
      pc_wen     = 1'b0;
      dnpc       = '0;

      // Reset state and first fetch with zero-wait memory.
      do_reset();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      chk("rst_pc", pc, RST_PC);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_fault", 64'(fetch_fault), 64'd0);
      chk("rst_fault_pc", fault_pc, 64'd0);
      wait_valid(50, n);
      chk("first_latency", 64'(n), 64'd2);

      // Decode stalls for 10 cycles.
      repeat (10) tick();
      chk("stall_pc", pc, RST_PC);
      chk("stall_inst", 64'(inst), 64'h13);
      chk("stall_no_req", 64'(imem_req_valid), 64'd0);

      // Sequential retire selects the upper word next.
      retire(1'b0, '0);
      chk("seq_req_valid", 64'(imem_req_valid), 64'd1);
      chk("seq_req_addr", imem_req_addr, 64'h8000_0004);
      chk("seq_pc", pc, 64'h8000_0004);
      wait_valid(50, n);
      chk("retire_latency", 64'(n), 64'd2);

      // Redirect.
      retire(1'b1, 64'h8000_0100);
      chk("redir_req_addr", imem_req_addr, 64'h8000_0100);
      chk("redir_pc", pc, 64'h8000_0100);
      wait_valid(50, n);

      // Memory not ready for 5 cycles: request held with a stable address.
      ready_pct = 0;
      tick();
      retire(1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
         chk("stall_req_addr", imem_req_addr, 64'h8000_0104);
         tick();
      end
      ready_pct = 100;
      wait_valid(50, n);
      retire(1'b0, '0);
      wait_valid(50, n);

      // Randomised traffic.
      ready_pct = 70;
      max_lat   = 3;
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         wen = ($urandom_range(0, 3) == 0);
         tgt = RST_PC + {50'd0, 12'($urandom_range(0, 1023)), 2'b00};
         retire(wen, tgt);
         wait_valid(200, n);
      end

      // PC wrap-around at the top of the address space.
      retire(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_valid(200, n);
      retire(1'b0, '0);
      chk("wrap_pc", pc, 64'd0);
      wait_valid(200, n);

      // Bus error on the third fetch.
      ready_pct = 100;
      max_lat   = 0;
      err_addr  = 64'h8000_0008;
      do_reset();
      wait_valid(50, n);
      retire(1'b0, '0);
      wait_valid(50, n);
      retire(1'b0, '0);
      wait_fault(50);
      chk("err_fault_pc", fault_pc, 64'h8000_0008);
      chk("err_inst_valid", 64'(inst_valid), 64'd0);
      chk("err_req_valid", 64'(imem_req_valid), 64'd0);
      inst_ready = 1'b1;
      pc_wen     = 1'b1;
      dnpc       = 64'h8000_0200;
      repeat (20) tick();
      inst_ready = 1'b0;
      chk("err_sticky", 64'(fetch_fault), 64'd1);
      chk("err_pc_frozen", pc, 64'h8000_0008);
      err_addr = '1;
      do_reset();
      chk("err_rst_pc", pc, RST_PC);
      chk("err_rst_req", 64'(imem_req_valid), 64'd1);
      chk("err_rst_fault", 64'(fetch_fault), 64'd0);
      wait_valid(50, n);

      // No response at all: fetch times out.
      mem_drop = 1'b1;
      do_reset();
      repeat (250) tick();
      chk("to_not_yet", 64'(fetch_fault), 64'd0);
      repeat (10) tick();
      chk("to_fault", 64'(fetch_fault), 64'd1);
      chk("to_fault_pc", fault_pc, RST_PC);
      repeat (20) tick();
      chk("to_sticky", 64'(fetch_fault), 64'd1);
      mem_drop = 1'b0;
      do_reset();
      chk("to_rst_pc", pc, RST_PC);
      wait_valid(50, n);

      // Misaligned redirect target.
      retire(1'b1, 64'h8000_0102);
      wait_fault(10);
      chk("mis_fault_pc", fault_pc, 64'h8000_0102);
      chk("mis_inst_valid", 64'(inst_valid), 64'd0);
      chk("mis_pc", pc, RST_PC);
      repeat (10) tick();
      chk("mis_sticky", 64'(fetch_fault), 64'd1);
      do_reset();
      chk("mis_rst_pc", pc, RST_PC);
      wait_valid(50, n);

      // Reset mid-WAIT, then a stale beat right after reset drops.
      retire(1'b0, '0);
      mem_drop = 1'b1;
      repeat (3) tick();
      mem_en          = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      rst             = 1'b1;
      tick();
      rst             = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
      imem_resp_err   = 1'b0;
      sb.delete();
      model_pc = RST_PC;
      push(RST_PC);
      tick();
      imem_resp_valid = 1'b0;
      chk("stale_inst_valid", 64'(inst_valid), 64'd0);
      chk("stale_req_valid", 64'(imem_req_valid), 64'd1);
      chk("stale_inst", 64'(inst), 64'd0);
      chk("stale_pc", pc, RST_PC);
      mem_drop = 1'b0;
      mem_en   = 1'b1;
      wait_valid(50, n);
      chk("stale_new_inst", 64'(inst), 64'h13);
      tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
